cnu_min_sched: RTL and testbench



---
 rtl/cnu_min_sched.sv | 154 +++++++++++++++
 tb/tb_cnu_min_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnu_min_sched.sv
// Sequential min1/min2/min1_idx finder for one check-node row (layer CNU).
// Optional CNU_MIN_SIGN_EN adds in_sign input and sign_prod XOR output.
module cnu_min_sched #(
  parameter  int QUAN_SIZE = 3,
  parameter  int DC        = 6,
  localparam int IDX_W     = $clog2(DC)
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DC*QUAN_SIZE-1:0] in_msg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [QUAN_SIZE-1:0]    min1,
  output logic [QUAN_SIZE-1:0]    min2,
  output logic [IDX_W-1:0]        min1_idx
`ifdef CNU_MIN_SIGN_EN
  ,
  input  logic [DC-1:0]           in_sign,
  output logic                    sign_prod
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DC - 1);
  localparam logic [QUAN_SIZE-1:0] ONES = {QUAN_SIZE{1'b1}};

  state_e state_q, state_d;

  logic [QUAN_SIZE-1:0] msg_q [DC];
  logic [QUAN_SIZE-1:0] msg_d [DC];
  logic [QUAN_SIZE-1:0] min1_q, min1_d;
  logic [QUAN_SIZE-1:0] min2_q, min2_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;

  logic [QUAN_SIZE-1:0] x;
  logic                 gt1;
  logic                 gt2;
  logic                 accept;

`ifdef CNU_MIN_SIGN_EN
  logic [DC-1:0] sgn_q, sgn_d;
  logic          sp_q, sp_d;
`endif

  assign x      = msg_q[cnt_q];
  assign gt1    = min1_q > x;
  assign gt2    = min2_q > x;
  assign accept = (state_q == IDLE) && in_valid;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = SCAN;
      SCAN: if (cnt_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msg_d  = msg_q;
    min1_d = min1_q;
    min2_d = min2_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
`ifdef CNU_MIN_SIGN_EN
    sgn_d  = sgn_q;
    sp_d   = sp_q;
`endif
    if (accept) begin
      for (int k = 0; k < DC; k++) begin
        msg_d[k] = in_msg[k*QUAN_SIZE +: QUAN_SIZE];
      end
      min1_d = in_msg[QUAN_SIZE-1:0];
      min2_d = ONES;
      idx_d  = '0;
      cnt_d  = IDX_W'(1);
`ifdef CNU_MIN_SIGN_EN
      sgn_d  = in_sign;
      sp_d   = in_sign[0];
`endif
    end else if (state_q == SCAN) begin
      // strict compares: ties never displace the earlier index
      if (gt1) begin
        min2_d = min1_q;
        min1_d = x;
        idx_d  = cnt_q;
      end else if (gt2) begin
        min2_d = x;
      end
      if (cnt_q != LAST) begin
        cnt_d = cnt_q + IDX_W'(1);
      end
`ifdef CNU_MIN_SIGN_EN
      sp_d = sp_q ^ sgn_q[cnt_q];
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DC; k++) begin
        msg_q[k] <= '0;
      end
      min1_q <= '0;
      min2_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      msg_q  <= msg_d;
      min1_q <= min1_d;
      min2_q <= min2_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef CNU_MIN_SIGN_EN
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sgn_q <= '0;
      sp_q  <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
      sp_q  <= sp_d;
    end
  end

  assign sign_prod = sp_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign min1      = min1_q;
  assign min2      = min2_q;
  assign min1_idx  = idx_q;

endmodule

// File: tb/tb_cnu_min_sched.sv
// Directed bench for cnu_min_sched (DC=6, QUAN_SIZE=3).
// Table vectors plus hold, back-to-back, mid-scan reset sequences.
module tb_cnu_min_sched;

  localparam int Q  = 3;
  localparam int DC = 6;
  localparam int IW = $clog2(DC);

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [DC*Q-1:0] in_msg;
  logic            out_valid;
  logic            out_ready;
  logic [Q-1:0]    min1;
  logic [Q-1:0]    min2;
  logic [IW-1:0]   min1_idx;
`ifdef CNU_MIN_SIGN_EN
  logic [DC-1:0]   in_sign;
  logic            sign_prod;
`endif

  int n_vec;
  int n_err;

  cnu_min_sched #(.QUAN_SIZE(Q), .DC(DC)) dut (
    .sys_clk  (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_msg   (in_msg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .min1     (min1),
    .min2     (min2),
    .min1_idx (min1_idx)
`ifdef CNU_MIN_SIGN_EN
    ,
    .in_sign  (in_sign),
    .sign_prod(sign_prod)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time expired, required finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [DC*Q-1:0] msg;
    int              e1;
    int              e2;
    int              ei;
  } vec_t;

  function automatic logic [DC*Q-1:0] pk(int a0, int a1, int a2,
                                         int a3, int a4, int a5);
    return {Q'(a5), Q'(a4), Q'(a3), Q'(a2), Q'(a1), Q'(a0)};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // drive a row at a negedge; returns at the negedge after the accept edge
  task automatic send(logic [DC*Q-1:0] m);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_send", int'(in_ready), 1);
    in_valid = 1'b1;
    in_msg   = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // counts cycles from accept to out_valid, expected DC-1
  task automatic wait_done(string name);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_latency"}, c, DC - 1);
  endtask

  task automatic check_res(string name, int e1, int e2, int ei);
    chk({name, "_min1"}, int'(min1), e1);
    chk({name, "_min2"}, int'(min2), e2);
    chk({name, "_idx"}, int'(min1_idx), ei);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
  endtask

  vec_t tv [6];

  initial begin
    int seen;
    n_vec     = 0;
    n_err     = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_msg    = '0;
`ifdef CNU_MIN_SIGN_EN
    in_sign   = '0;
`endif

    tv[0] = '{pk(5,3,6,1,4,2), 1, 2, 3};
    tv[1] = '{pk(4,4,4,4,4,4), 4, 4, 0};
    tv[2] = '{pk(2,2,1,3,0,5), 0, 1, 4};
    tv[3] = '{pk(7,7,7,7,7,7), 7, 7, 0};
    tv[4] = '{pk(3,1,1,2,0,0), 0, 0, 4};
    tv[5] = '{pk(6,5,4,3,2,1), 1, 2, 5};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    check_res("rst", 0, 0, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(tv[i].msg);
      chk("scan_in_ready", int'(in_ready), 0);
      wait_done($sformatf("vec%0d", i));
      check_res($sformatf("vec%0d", i), tv[i].e1, tv[i].e2, tv[i].ei);
      release_out();
    end

    // hold in DONE with out_ready low; in_valid pulses must be ignored
    send(pk(0,7,7,7,7,7));
    wait_done("hold");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_msg   = pk(1,1,1,1,1,1);
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      check_res("hold", 0, 7, 0);
    end
    in_valid = 1'b0;
    release_out();

    // back-to-back: in_valid and out_ready together in DONE
    send(pk(6,6,2,5,3,4));
    wait_done("b2b_a");
    check_res("b2b_a", 2, 3, 2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_msg    = pk(3,5,1,1,6,0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle_out_valid", int'(out_valid), 0);
    chk("b2b_idle_in_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepted", int'(in_ready), 0);
    wait_done("b2b_b");
    check_res("b2b_b", 0, 1, 5);
    release_out();

    // async reset at cnt=3 aborts the row
    send(pk(5,6,7,6,5,6));
    repeat (2) @(negedge clk);
    chk("pre_rst_min1", int'(min1), 5);
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    check_res("midrst", 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("midrst_no_stale_valid", seen, 0);
    chk("midrst_in_ready_after", int'(in_ready), 1);
    send(pk(2,2,1,3,0,5));
    wait_done("postrst");
    check_res("postrst", 0, 1, 4);
    release_out();

`ifdef CNU_MIN_SIGN_EN
    in_sign = 6'b101101;
    send(pk(1,2,3,4,5,6));
    in_sign = 6'b000000;
    wait_done("sign_a");
    chk("sign_a_prod", int'(sign_prod), 0);
    release_out();
    in_sign = 6'b000001;
    send(pk(1,2,3,4,5,6));
    in_sign = 6'b000000;
    wait_done("sign_b");
    chk("sign_b_prod", int'(sign_prod), 1);
    release_out();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
